// File: rtl/td4_counter_pkg.sv
// rtl/td4_counter_pkg.sv - shared direction constants and wrap arithmetic for td4_counter
package td4_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Next counter value plus a flag telling whether the step crossed the terminal count
  typedef struct packed {
    logic [31:0] value;
    logic        wrap;
  } wrap_t;

  // One count step in the given direction, with wrap at MAX (up) or 0 (down).
  // Widths are fixed at 32 bits so narrower counters zero-extend in and truncate out.
  function automatic wrap_t wrap_next(input logic [31:0] value,
                                      input logic [31:0] max,
                                      input logic        dir);
    wrap_t r;
    r.value = value;
    r.wrap  = 1'b0;
    if (dir == DIR_UP) begin
      if (value >= max) begin
        r.value = 32'd0;
        r.wrap  = 1'b1;
      end else begin
        r.value = value + 32'd1;
      end
    end else begin
      if (value == 32'd0) begin
        r.value = max;
        r.wrap  = 1'b1;
      end else begin
        r.value = value - 32'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/td4_counter_if.sv
// rtl/td4_counter_if.sv - control/data bundle for td4_counter; up exists only with TD4_COUNTER_UPDOWN_EN
interface td4_counter_if #(
  parameter int unsigned WIDTH = 4
);

  logic             load_n;
  logic             enp;
  logic             ent;
  logic             clr_ovf;
`ifdef TD4_COUNTER_UPDOWN_EN
  logic             up;
`endif
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic             rco;
  logic             ovf;

`ifdef TD4_COUNTER_UPDOWN_EN
  modport master (output load_n, enp, ent, clr_ovf, up, in,
                  input  out, rco, ovf);
  modport slave  (input  load_n, enp, ent, clr_ovf, up, in,
                  output out, rco, ovf);
`else
  modport master (output load_n, enp, ent, clr_ovf, in,
                  input  out, rco, ovf);
  modport slave  (input  load_n, enp, ent, clr_ovf, in,
                  output out, rco, ovf);
`endif

endinterface

// File: rtl/td4_counter_tc.sv
// rtl/td4_counter_tc.sv - combinational terminal-count detector; down terminal only with TD4_COUNTER_UPDOWN_EN
module td4_counter_tc
  import td4_counter_pkg::*;
#(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic [WIDTH-1:0] value,
`ifdef TD4_COUNTER_UPDOWN_EN
  input  logic             dir,
`endif
  output logic             terminal
);

  // Terminal is ">= MAX" going up so loaded values above MAX still wrap to 0
  always_comb begin
    terminal = 1'b0;
`ifdef TD4_COUNTER_UPDOWN_EN
    if (dir == DIR_DOWN) begin
      terminal = (value == '0);
    end else begin
      terminal = (value >= MAX);
    end
`else
    terminal = (value >= MAX);
`endif
  end

endmodule

// File: rtl/td4_counter.sv
// rtl/td4_counter.sv - cascadable modulo-N counter with load, dual enables, rco and sticky ovf; TD4_COUNTER_UPDOWN_EN adds down count
module td4_counter
  import td4_counter_pkg::*;
#(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] MAX       = '1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic           clk,
  input logic           rst,
  td4_counter_if.slave  bus
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic             dir;
  logic             terminal;
  logic             count_en;
  logic             wrap_event;
  wrap_t            step_r;
  logic             unused_step;

`ifdef TD4_COUNTER_UPDOWN_EN
  assign dir = bus.up;
`else
  assign dir = DIR_UP;
`endif

  td4_counter_tc #(
    .WIDTH (WIDTH),
    .MAX   (MAX)
  ) u_tc (
    .value    (out_q),
`ifdef TD4_COUNTER_UPDOWN_EN
    .dir      (dir),
`endif
    .terminal (terminal)
  );

  // Count requires both enables; load overrides counting and never records a wrap
  assign count_en   = bus.enp & bus.ent;
  assign wrap_event = bus.load_n & count_en & terminal;
  assign step_r     = wrap_next(32'(out_q), 32'(MAX), dir);

  // The wrap bit and the bits above WIDTH are redundant with the terminal detector
  assign unused_step = ^step_r;

  // Priority mux for the next value and the sticky wrap flag (set beats clear)
  always_comb begin
    out_d = out_q;
    ovf_d = ovf_q;
    if (!bus.load_n) begin
      out_d = bus.in;
    end else if (count_en) begin
      out_d = WIDTH'(step_r.value);
    end
    if (bus.clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (wrap_event) begin
      ovf_d = 1'b1;
    end
  end

  // State registers; reset dominates load and count and suppresses the wrap flag
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= RESET_VAL;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.out = out_q;
  assign bus.ovf = ovf_q;
  assign bus.rco = bus.ent & terminal;

endmodule

// File: tb/tb_td4_counter.sv
// tb/tb_td4_counter.sv - randomized self-checking bench for td4_counter; honours TD4_COUNTER_UPDOWN_EN
module tb_td4_counter;

  logic clk = 1'b0;
  logic rst;
  logic load_n;
  logic enp;
  logic clr_ovf;
  logic up_v;
  logic ent_v [3];
  logic [3:0] in_v [4];

  logic [3:0] act_out [4];
  logic       act_rco [4];
  logic       act_ovf [4];

  int unsigned m_out [4];
  bit          m_ovf [4];
  int unsigned m_max [4] = '{15, 9, 15, 15};

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  td4_counter_if #(.WIDTH(4)) a_if ();
  td4_counter_if #(.WIDTH(4)) d_if ();
  td4_counter_if #(.WIDTH(4)) lo_if ();
  td4_counter_if #(.WIDTH(4)) hi_if ();

  td4_counter #(.WIDTH(4), .MAX(4'd15), .RESET_VAL(4'd0)) u_a  (.clk(clk), .rst(rst), .bus(a_if.slave));
  td4_counter #(.WIDTH(4), .MAX(4'd9),  .RESET_VAL(4'd0)) u_d  (.clk(clk), .rst(rst), .bus(d_if.slave));
  td4_counter #(.WIDTH(4), .MAX(4'd15), .RESET_VAL(4'd0)) u_lo (.clk(clk), .rst(rst), .bus(lo_if.slave));
  td4_counter #(.WIDTH(4), .MAX(4'd15), .RESET_VAL(4'd0)) u_hi (.clk(clk), .rst(rst), .bus(hi_if.slave));

  assign a_if.load_n  = load_n;
  assign d_if.load_n  = load_n;
  assign lo_if.load_n = load_n;
  assign hi_if.load_n = load_n;
  assign a_if.enp     = enp;
  assign d_if.enp     = enp;
  assign lo_if.enp    = enp;
  assign hi_if.enp    = enp;
  assign a_if.clr_ovf  = clr_ovf;
  assign d_if.clr_ovf  = clr_ovf;
  assign lo_if.clr_ovf = clr_ovf;
  assign hi_if.clr_ovf = clr_ovf;
  assign a_if.ent  = ent_v[0];
  assign d_if.ent  = ent_v[1];
  assign lo_if.ent = ent_v[2];
  assign hi_if.ent = lo_if.rco;
  assign a_if.in  = in_v[0];
  assign d_if.in  = in_v[1];
  assign lo_if.in = in_v[2];
  assign hi_if.in = in_v[3];
`ifdef TD4_COUNTER_UPDOWN_EN
  assign a_if.up  = up_v;
  assign d_if.up  = up_v;
  assign lo_if.up = up_v;
  assign hi_if.up = up_v;
`endif

  assign act_out[0] = a_if.out;
  assign act_out[1] = d_if.out;
  assign act_out[2] = lo_if.out;
  assign act_out[3] = hi_if.out;
  assign act_rco[0] = a_if.rco;
  assign act_rco[1] = d_if.rco;
  assign act_rco[2] = lo_if.rco;
  assign act_rco[3] = hi_if.rco;
  assign act_ovf[0] = a_if.ovf;
  assign act_ovf[1] = d_if.ovf;
  assign act_ovf[2] = lo_if.ovf;
  assign act_ovf[3] = hi_if.ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_term(input int i);
    if (up_v) return (m_out[i] >= m_max[i]);
    return (m_out[i] == 0);
  endfunction

  function automatic bit m_rco(input int i);
    bit e;
    if (i == 3) e = ent_v[2] & m_term(2);
    else        e = ent_v[i];
    return e & m_term(i);
  endfunction

  task automatic check_rco_all(input string what);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("%s rco[%0d]", what, i), 32'(act_rco[i]), 32'(m_rco(i)));
  endtask

  // Inputs are already set; check combinational rco, advance one edge, then check state
  task automatic step(input string what);
    int unsigned nxt [4];
    bit          nov [4];
    bit          en;
    #1;
    check_rco_all({what, " pre"});
    for (int i = 0; i < 4; i++) begin
      en     = enp & ((i == 3) ? m_rco(2) : ent_v[i]);
      nxt[i] = m_out[i];
      nov[i] = m_ovf[i];
      if (rst) begin
        nxt[i] = 0;
        nov[i] = 0;
      end else begin
        if (clr_ovf) nov[i] = 0;
        if (!load_n) begin
          nxt[i] = in_v[i];
        end else if (en) begin
          if (up_v) begin
            if (m_out[i] >= m_max[i]) begin nxt[i] = 0; nov[i] = 1; end
            else nxt[i] = m_out[i] + 1;
          end else begin
            if (m_out[i] == 0) begin nxt[i] = m_max[i]; nov[i] = 1; end
            else nxt[i] = m_out[i] - 1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    m_out = nxt;
    m_ovf = nov;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("%s out[%0d]", what, i), 32'(act_out[i]), 32'(m_out[i]));
      check_eq($sformatf("%s ovf[%0d]", what, i), 32'(act_ovf[i]), 32'(m_ovf[i]));
    end
    check_rco_all(what);
  endtask

  task automatic set_ent(input logic v);
    for (int i = 0; i < 3; i++) ent_v[i] = v;
  endtask

  task automatic set_in(input logic [3:0] v);
    for (int i = 0; i < 4; i++) in_v[i] = v;
  endtask

  initial begin
    rst = 1'b1; load_n = 1'b1; enp = 1'b0; clr_ovf = 1'b0; up_v = 1'b1;
    set_ent(1'b0);
    set_in(4'd0);
    for (int i = 0; i < 4; i++) begin m_out[i] = 0; m_ovf[i] = 0; end
    @(posedge clk);
    #1;

    // Reset state
    step("reset");
    check_eq("reset out", 32'(act_out[0]), 32'd0);
    check_eq("reset ovf", 32'(act_ovf[0]), 32'd0);
    rst = 1'b0;

    // Load and hold
    load_n = 1'b0; set_in(4'b1010);
    step("load");
    check_eq("load out", 32'(act_out[0]), 32'd10);
    load_n = 1'b1; enp = 1'b0; set_ent(1'b0);
    step("hold");
    check_eq("hold out", 32'(act_out[0]), 32'd10);

    // Up wrap through MAX
    load_n = 1'b0; set_in(4'b1110);
    step("load14");
    load_n = 1'b1; enp = 1'b1; set_ent(1'b1);
    step("up1");
    check_eq("up1 out", 32'(act_out[0]), 32'd15);
    check_eq("up1 rco", 32'(act_rco[0]), 32'd1);
    step("up2");
    check_eq("wrap out", 32'(act_out[0]), 32'd0);
    check_eq("wrap ovf", 32'(act_ovf[0]), 32'd1);
    step("up3");
    check_eq("up3 out", 32'(act_out[0]), 32'd1);
    enp = 1'b0; clr_ovf = 1'b1;
    step("clr");
    check_eq("clr ovf", 32'(act_ovf[0]), 32'd0);
    clr_ovf = 1'b0;

    // Decade counter: 0..9, 0 and rco only at 9
    rst = 1'b1;
    step("dec rst");
    rst = 1'b0; enp = 1'b1; set_ent(1'b1);
    for (int k = 1; k <= 10; k++) begin
      step("dec");
      check_eq($sformatf("dec out k=%0d", k), 32'(act_out[1]), 32'(k % 10));
      check_eq($sformatf("dec rco k=%0d", k), 32'(act_rco[1]), 32'((k % 10) == 9));
    end
    load_n = 1'b0; set_in(4'd12);
    step("dec load12");
    check_eq("dec load12 out", 32'(act_out[1]), 32'd12);
    load_n = 1'b1;
    step("dec over");
    check_eq("dec over out", 32'(act_out[1]), 32'd0);
    check_eq("dec over ovf", 32'(act_ovf[1]), 32'd1);

    // Cascade: 0x0F -> 0x10, then hold 0x0F with rco_low asserted
    load_n = 1'b0; in_v[2] = 4'hF; in_v[3] = 4'h0;
    step("cas load");
    load_n = 1'b1; enp = 1'b1; set_ent(1'b1);
    step("cas count");
    check_eq("cas value", 32'({act_out[3], act_out[2]}), 32'h10);
    load_n = 1'b0; in_v[2] = 4'hF; in_v[3] = 4'h0;
    step("cas reload");
    load_n = 1'b1; enp = 1'b0; ent_v[2] = 1'b1;
    step("cas hold");
    check_eq("cas hold value", 32'({act_out[3], act_out[2]}), 32'h0F);
    check_eq("cas rco_low", 32'(act_rco[2]), 32'd1);

`ifdef TD4_COUNTER_UPDOWN_EN
    // Down wrap with simultaneous clr_ovf: set wins
    rst = 1'b1;
    step("dn rst");
    rst = 1'b0; load_n = 1'b0; set_in(4'd1);
    step("dn load");
    load_n = 1'b1; up_v = 1'b0; enp = 1'b1; set_ent(1'b1);
    step("dn1");
    check_eq("dn1 out", 32'(act_out[0]), 32'd0);
    check_eq("dn1 rco", 32'(act_rco[0]), 32'd1);
    clr_ovf = 1'b1;
    step("dn2");
    check_eq("dn2 out", 32'(act_out[0]), 32'd15);
    check_eq("dn2 ovf", 32'(act_ovf[0]), 32'd1);
    clr_ovf = 1'b0; up_v = 1'b1;
`endif

    // Priority: reset beats load and count; load beats count
    rst = 1'b1; load_n = 1'b0; enp = 1'b1; set_ent(1'b1); set_in(4'd7);
    step("prio rst");
    check_eq("prio rst out", 32'(act_out[0]), 32'd0);
    check_eq("prio rst ovf", 32'(act_ovf[0]), 32'd0);
    rst = 1'b0; set_in(4'd5);
    step("prio load");
    check_eq("prio load out", 32'(act_out[0]), 32'd5);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom_range(0, 49) == 0);
      load_n  = ($urandom_range(0, 7) != 0);
      enp     = ($urandom_range(0, 3) != 0);
      clr_ovf = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < 3; i++) ent_v[i] = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) in_v[i] = 4'($urandom_range(0, 15));
`ifdef TD4_COUNTER_UPDOWN_EN
      if ($urandom_range(0, 7) == 0) up_v = ~up_v;
`endif
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
